// File: rtl/gray_pkg.sv
// gray_pkg: shared types and helpers for the gray-to-binary position tracker.
//   tracker_state_t : tracker FSM states (IDLE / TRACK / ERROR)
//   POS_W           : width of the signed step accumulator
//   MAX_W           : widest gray code the conversion helper handles
//   gray_to_bin()   : gray -> binary conversion for a code of width w (w <= MAX_W)
`timescale 1ns/1ps
package gray_pkg;

  localparam int POS_W = 16;
  localparam int MAX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_ERROR = 2'd2
  } tracker_state_t;

  // b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i]. Bits at or above w are forced to 0,
  // so the running XOR starts cleanly at the code's own MSB.
  function automatic logic [MAX_W-1:0] gray_to_bin(input logic [MAX_W-1:0] g,
                                                   input int w);
    logic [MAX_W-1:0] b;
    b = '0;
    b[MAX_W-1] = (w >= MAX_W) ? g[MAX_W-1] : 1'b0;
    for (int i = MAX_W-2; i >= 0; i--) begin
      b[i] = (i < w) ? (b[i+1] ^ g[i]) : 1'b0;
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: W-bit wide, DEPTH-deep flop chain used to bring an asynchronous
// bus into the clk domain. Every stage clears on async active-low reset.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset
//   d_i   : asynchronous input bus
//   q_o   : output of the last stage
`timescale 1ns/1ps
module sync_ff #(
  parameter int W     = 4,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/gray2binary_tracker.sv
// gray2binary_tracker: synchronizes an asynchronous gray-coded position,
// converts it to binary and tracks single-code steps into a signed counter.
//   clk        : sole clock, rising edge
//   rst_n      : asynchronous active-low reset
//   gray_in    : asynchronous gray-coded position (WIDTH bits)
//   enable     : tracking enable; low returns the tracker to IDLE
//   clear_err  : single-cycle request to leave ERROR
//   binary_out : registered binary of the synchronized code (SYNC_STAGES+1 latency)
//   valid_out  : binary_out is meaningful (state TRACK or ERROR)
//   step_up    : one-cycle pulse on a +1 code step
//   step_down  : one-cycle pulse on a -1 code step
//   skip_err   : one-cycle pulse on an illegal multi-code jump
//   err_sticky : high while in ERROR
//   position   : signed two's-complement step accumulator (wraps mod 2^16)
//   state_dbg  : current FSM state, for observation only
//
// Output qualifier: valid_out has no ready counterpart; a consumer may sample
// binary_out on any cycle where valid_out is high, and the pulses/position
// change on the same edge that updates binary_out.
`timescale 1ns/1ps
module gray2binary_tracker
  import gray_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     gray_in,
  input  logic                 enable,
  input  logic                 clear_err,
  output logic [WIDTH-1:0]     binary_out,
  output logic                 valid_out,
  output logic                 step_up,
  output logic                 step_down,
  output logic                 skip_err,
  output logic                 err_sticky,
  output logic [POS_W-1:0]     position,
  output tracker_state_t       state_dbg
);

  logic [WIDTH-1:0] gray_sync;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] binary_q;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             first_q, first_d;
  logic             up_q, up_d;
  logic             dn_q, dn_d;
  logic             skip_q, skip_d;
  logic             is_up, is_dn, is_jump;
  tracker_state_t   state_q, state_d;

  sync_ff #(
    .W     (WIDTH),
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (gray_in),
    .q_o   (gray_sync)
  );

  assign cur = WIDTH'(gray_to_bin(MAX_W'(gray_sync), WIDTH));

  // Modular +/-1 comparison gives the wrap cases (max->0 up, 0->max down) for free.
  assign is_up = (cur == prev_q + WIDTH'(1));
  assign is_dn = (cur == prev_q - WIDTH'(1));

  // prev is not trustworthy on the first TRACK cycle, so nothing is a jump then.
  assign is_jump = (state_q != ST_IDLE) && !first_q &&
                   (cur != prev_q) && !is_up && !is_dn;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a jump outranks clear_err in ERROR.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (enable) state_d = ST_TRACK;
      ST_TRACK: begin
        if (!enable)      state_d = ST_IDLE;
        else if (is_jump) state_d = ST_ERROR;
      end
      ST_ERROR: begin
        if (!enable)                     state_d = ST_IDLE;
        else if (!is_jump && clear_err)  state_d = ST_TRACK;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    valid_out  = (state_q != ST_IDLE);
    err_sticky = (state_q == ST_ERROR);
    state_dbg  = state_q;
  end

  // Tracking datapath next-state
  always_comb begin
    prev_d  = prev_q;
    first_d = first_q;
    pos_d   = pos_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    skip_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      first_d = 1'b1;
    end else begin
      prev_d  = cur;
      first_d = 1'b0;
      // Pulses are suppressed on the cycle the tracker is leaving for IDLE.
      if (enable && !first_q) begin
        if (is_jump) begin
          skip_d = 1'b1;
        end else if (state_q == ST_TRACK && is_up) begin
          up_d  = 1'b1;
          pos_d = pos_q + POS_W'(1);
        end else if (state_q == ST_TRACK && is_dn) begin
          dn_d  = 1'b1;
          pos_d = pos_q - POS_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q   <= '0;
      binary_q <= '0;
      pos_q    <= '0;
      first_q  <= 1'b1;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      skip_q   <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      binary_q <= cur;
      pos_q    <= pos_d;
      first_q  <= first_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      skip_q   <= skip_d;
    end
  end

  assign binary_out = binary_q;
  assign position   = pos_q;
  assign step_up    = up_q;
  assign step_down  = dn_q;
  assign skip_err   = skip_q;

endmodule

// File: tb/tb_gray2binary_tracker.sv
`timescale 1ns/1ps
module tb_gray2binary_tracker;
  import gray_pkg::*;

  logic           clk;
  logic           rst_n;
  logic [3:0]     gray_in;
  logic           enable;
  logic           clear_err;
  logic [3:0]     binary_out;
  logic           valid_out;
  logic           step_up;
  logic           step_down;
  logic           skip_err;
  logic           err_sticky;
  logic [15:0]    position;
  tracker_state_t state_dbg;

  int n_vec;
  int n_err;
  int n_up;
  int n_dn;
  int n_skip;

  logic [3:0] exp_q[$];

  gray2binary_tracker #(
    .WIDTH       (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gray_in    (gray_in),
    .enable     (enable),
    .clear_err  (clear_err),
    .binary_out (binary_out),
    .valid_out  (valid_out),
    .step_up    (step_up),
    .step_down  (step_down),
    .skip_err   (skip_err),
    .err_sticky (err_sticky),
    .position   (position),
    .state_dbg  (state_dbg)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; sample 1ns after the edge and tally pulses.
  task automatic tick();
    int sum;
    @(posedge clk);
    #1;
    n_up   += int'(step_up);
    n_dn   += int'(step_down);
    n_skip += int'(skip_err);
    sum = int'(step_up) + int'(step_down) + int'(skip_err);
    check("pulse_exclusive", (sum <= 1) ? 1 : 0, 1);
  endtask

  task automatic clear_counts();
    n_up = 0; n_dn = 0; n_skip = 0;
  endtask

  // Drive a code, expect its binary three clocks later, then one idle clock.
  task automatic apply_step(input logic [3:0] bin);
    logic [3:0] e;
    gray_in = to_gray(bin);
    exp_q.push_back(bin);
    tick(); tick(); tick();
    e = exp_q.pop_front();
    check("binary_out", int'(binary_out), int'(e));
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; clear_err = 1'b0; gray_in = 4'h0;
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    enable = 1'b1;
    tick(); tick(); tick(); tick();
    clear_counts();
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    clear_counts();
    rst_n = 1'b0; enable = 1'b0; clear_err = 1'b0; gray_in = 4'h0;
    #12;
    // Reset state
    check("rst_valid", int'(valid_out), 0);
    check("rst_binary", int'(binary_out), 0);
    check("rst_position", int'($signed(position)), 0);
    check("rst_state", int'(state_dbg), int'(ST_IDLE));

    // Enable with gray 0000 held
    do_reset();
    check("en_valid", int'(valid_out), 1);
    check("en_binary", int'(binary_out), 0);
    check("en_position", int'($signed(position)), 0);
    check("en_state", int'(state_dbg), int'(ST_TRACK));
    check("en_no_pulses", n_up + n_dn + n_skip, 0);

    // Ascending walk including wrap 15 -> 0
    for (int i = 1; i <= 16; i++) apply_step(4'(i));
    check("up_count", n_up, 16);
    check("up_down_count", n_dn, 0);
    check("up_position", int'($signed(position)), 16);

    // enable low -> IDLE, position held
    enable = 1'b0;
    tick(); tick();
    check("dis_valid", int'(valid_out), 0);
    check("dis_state", int'(state_dbg), int'(ST_IDLE));
    check("dis_position", int'($signed(position)), 16);

    // Descending walk from 0 (first step wraps to 15)
    do_reset();
    apply_step(4'd15);
    check("dn_first_count", n_dn, 1);
    for (int i = 14; i >= 0; i--) apply_step(4'(i));
    check("dn_count", n_dn, 16);
    check("dn_up_count", n_up, 0);
    check("dn_position", int'($signed(position)), -16);

    // Illegal jump 2 -> 4, stepping in ERROR, then clear
    do_reset();
    apply_step(4'd1);
    apply_step(4'd2);
    clear_counts();
    apply_step(4'd4);
    check("jump_skip", n_skip, 1);
    check("jump_err", int'(err_sticky), 1);
    check("jump_position", int'($signed(position)), 2);
    apply_step(4'd5);
    check("err_no_up", n_up, 0);
    check("err_position", int'($signed(position)), 2);
    check("err_skip", n_skip, 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    tick();
    check("clr_err", int'(err_sticky), 0);
    check("clr_state", int'(state_dbg), int'(ST_TRACK));
    apply_step(4'd6);
    check("clr_up", n_up, 1);
    check("clr_position", int'($signed(position)), 3);

    // clear_err coinciding with an illegal jump 0 -> 8
    do_reset();
    apply_step(4'd5);
    check("cj_enter_err", int'(err_sticky), 1);
    apply_step(4'd0);
    check("cj_reskip", n_skip, 2);
    gray_in = to_gray(4'd8);
    exp_q.push_back(4'd8);
    tick(); tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("cj_skip_pulse", int'(skip_err), 1);
    check("cj_err", int'(err_sticky), 1);
    begin
      logic [3:0] e;
      e = exp_q.pop_front();
      check("cj_binary", int'(binary_out), int'(e));
    end
    tick();
    check("cj_err_hold", int'(err_sticky), 1);
    check("cj_skip_total", n_skip, 3);

    // Position wrap: 32767 up-steps at one code per clock, then one more
    do_reset();
    for (int k = 1; k <= 32767; k++) begin
      gray_in = to_gray(4'(k));
      tick();
    end
    tick(); tick(); tick();
    check("wrap_max", int'($signed(position)), 32767);
    check("wrap_up_count", n_up, 32767);
    apply_step(4'd0);
    check("wrap_min", int'($signed(position)), -32768);

    // Async reset mid-walk
    gray_in = to_gray(4'd1);
    tick();
    gray_in = to_gray(4'd2);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_binary", int'(binary_out), 0);
    check("ar_position", int'($signed(position)), 0);
    check("ar_valid", int'(valid_out), 0);
    check("ar_pulses", int'(step_up) + int'(step_down) + int'(skip_err), 0);
    check("ar_err", int'(err_sticky), 0);
    check("ar_state", int'(state_dbg), int'(ST_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
